round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
//   Parametrised round sequencer and data-path selector for the cipher core.
//   A rising edge on GLOBAL_EN starts a run: OUT presents CT (ciphertext/seed) for round 0,
//   then the round-function feedback IN for rounds 1..ROUNDS-1, with EN high throughout.
//   Adds lane/width/round parametrisation, stall, abort, restart, a done pulse and a held result.
// PARAMETERS
//   LANES      4   number of byte-lanes in the data path
//   LANE_W     8   bits per lane; data width DW = LANES*LANE_W
//   ROUNDS     32  rounds per run (>=2)
//   HOLD_RES   1   1: OUT shows latched result after completion; 0: OUT returns to CT
//   (local) CW = $clog2(ROUNDS) round-counter width
// PORTS
//   CLK        in   1    clock, all state on rising edge
//   RST_N      in   1    asynchronous active-low reset
//   GLOBAL_EN  in   1    run enable; rising edge starts/restarts, low level stalls
//   ABORT      in   1    synchronous abort to IDLE, priority over everything but RST_N
//   CT         in   DW   initial block, presented on OUT in round 0 and in IDLE
//   IN         in   DW   round-function feedback, presented on OUT in rounds >=1
//   OUT        out  DW   selected data path (combinational mux, registered select)
//   EN         out  1    round engine enable, high in RUN
//   ROUND      out  CW   current round index
//   BUSY       out  1    high in RUN
//   DONE       out  1    one-cycle pulse on run completion
// BEHAVIOUR
//   Reset: state=IDLE, EN=0, BUSY=0, DONE=0, ROUND=0, result reg=0, en_q=0; OUT=CT.
//   en_q <= GLOBAL_EN each cycle; rise = GLOBAL_EN & ~en_q.
//   States: IDLE, RUN, FIN.
//   IDLE: OUT=CT. On rise -> RUN, ROUND=0.
//   RUN: EN=1, BUSY=1. OUT = (ROUND==0) ? CT : IN.
//     GLOBAL_EN=1: if ROUND==ROUNDS-1 -> FIN, result<=IN, DONE=1 next cycle; else ROUND+=1.
//     GLOBAL_EN=0: stall, ROUND held, EN stays 1, OUT unchanged selection.
//     rise while in RUN (after a stall): restart, ROUND<=0, result untouched.
//   FIN: EN=0, BUSY=0, ROUND=0. DONE high only first cycle in FIN.
//     OUT = HOLD_RES ? result : CT. On rise -> RUN, ROUND=0 (DONE still pulses if entering).
//   ABORT=1 (any state): -> IDLE next edge, ROUND=0, EN=0, DONE=0; result preserved.
//     ABORT and rise same cycle: ABORT wins, rise ignored (en_q still updates).
//   Latency: EN rises 1 cycle after GLOBAL_EN rise; run length ROUNDS unstalled cycles;
//     DONE 1 cycle after last round cycle; round counter never wraps (capped at ROUNDS-1).
//   RST_N low mid-run: immediate return to reset values, no DONE.
//   No X on OUT after reset; IN/CT purely pass through the mux (no arithmetic).
// TESTING
//   1 Reset, CT=32'hA1B2C3D4 -> OUT=A1B2C3D4, EN=0, BUSY=0, DONE=0, ROUND=0.
//   2 GLOBAL_EN 0->1 held, IN=32'h11223344 -> EN=1 next cycle, ROUND 0..31 over 32 cycles,
//     OUT=CT at ROUND 0 else IN; DONE one pulse; FIN OUT=11223344 (HOLD_RES=1).
//   3 Drop GLOBAL_EN at ROUND=10 for 5 cycles -> ROUND stays 10, EN=1; re-raise -> ROUND=0 restart.
//   4 ABORT at ROUND=20 -> IDLE next cycle, EN=0, no DONE, OUT=CT; ABORT+rise same cycle stays IDLE.
//   5 RST_N low at ROUND=15 -> all outputs reset asynchronously; HOLD_RES=0 build: FIN OUT=CT.
//   6 LANES=2, LANE_W=16, ROUNDS=10 -> run length 10, ROUND width 4, DONE after 10th round.

Source files
------------

// File: rtl/round_sequencer.sv
// Round sequencer for the cipher core: steps ROUNDS rounds per run and selects
// seed, round feedback or the held result onto the OUT data path.
module round_sequencer #(
   parameter  int LANES    = 4,
   parameter  int LANE_W   = 8,
   parameter  int ROUNDS   = 32,
   parameter  int HOLD_RES = 1,
   localparam int DW       = LANES * LANE_W,
   localparam int CW       = $clog2(ROUNDS)
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          GLOBAL_EN,
   input  logic          ABORT,
   input  logic [DW-1:0] CT,
   input  logic [DW-1:0] IN,
   output logic [DW-1:0] OUT,
   output logic          EN,
   output logic [CW-1:0] ROUND,
   output logic          BUSY,
   output logic          DONE
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   localparam logic [CW-1:0] LAST_RND = CW'(ROUNDS - 1);

   logic [1:0]    state_q;
   logic [CW-1:0] round_q;
   logic [DW-1:0] result_q;
   logic          done_q;
   logic          en_q;
   logic          rise;

   assign rise = GLOBAL_EN & ~en_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         round_q  <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         en_q     <= 1'b0;
      end else begin
         en_q   <= GLOBAL_EN;
         done_q <= 1'b0;
         if (ABORT) begin
            state_q <= S_IDLE;
            round_q <= '0;
         end else begin
            case (state_q)
               S_IDLE, S_FIN: begin
                  if (rise) begin
                     state_q <= S_RUN;
                     round_q <= '0;
                  end
               end
               S_RUN: begin
                  // A rise here can only follow a stall, and it restarts the run.
                  if (rise) begin
                     round_q <= '0;
                  end else if (GLOBAL_EN) begin
                     if (round_q == LAST_RND) begin
                        state_q  <= S_FIN;
                        round_q  <= '0;
                        result_q <= IN;
                        done_q   <= 1'b1;
                     end else begin
                        round_q <= round_q + 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  round_q <= '0;
               end
            endcase
         end
      end
   end

   // Data path is a pure mux; only the select comes from registered state.
   always_comb begin
      OUT = CT;
      case (state_q)
         S_RUN:   if (round_q != '0) OUT = IN;
         S_FIN:   if (HOLD_RES != 0) OUT = result_q;
         default: OUT = CT;
      endcase
   end

   assign EN    = (state_q == S_RUN);
   assign BUSY  = (state_q == S_RUN);
   assign ROUND = round_q;
   assign DONE  = done_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: three builds (default, HOLD_RES=0, 2x16-bit/10 rounds)
// share one stimulus stream and are compared against a behavioural run model.
module tb_round_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        global_en;
   logic        abort;
   logic [31:0] ct;
   logic [31:0] in_d;

   logic [31:0] out0, out1, out2;
   logic        en0, en1, en2, busy0, busy1, busy2, done0, done1, done2;
   logic [4:0]  round0, round1;
   logic [3:0]  round2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   round_sequencer dut0 (
      .CLK(clk), .RST_N(rst_n), .GLOBAL_EN(global_en), .ABORT(abort), .CT(ct), .IN(in_d),
      .OUT(out0), .EN(en0), .ROUND(round0), .BUSY(busy0), .DONE(done0));

   round_sequencer #(.HOLD_RES(0)) dut1 (
      .CLK(clk), .RST_N(rst_n), .GLOBAL_EN(global_en), .ABORT(abort), .CT(ct), .IN(in_d),
      .OUT(out1), .EN(en1), .ROUND(round1), .BUSY(busy1), .DONE(done1));

   round_sequencer #(.LANES(2), .LANE_W(16), .ROUNDS(10)) dut2 (
      .CLK(clk), .RST_N(rst_n), .GLOBAL_EN(global_en), .ABORT(abort), .CT(ct), .IN(in_d),
      .OUT(out2), .EN(en2), .ROUND(round2), .BUSY(busy2), .DONE(done2));

   // Behavioural model: per build, whether a run is active, how many rounds in,
   // whether a completed run is being shown, and the captured result.
   int          m_rounds [3] = '{32, 32, 10};
   bit          m_hold   [3] = '{1'b1, 1'b0, 1'b1};
   bit          m_run    [3];
   bit          m_fin    [3];
   bit          m_done   [3];
   int          m_round  [3];
   logic [31:0] m_res    [3];
   bit          m_prev;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_run[i] = 0; m_fin[i] = 0; m_done[i] = 0; m_round[i] = 0; m_res[i] = '0;
      end
      m_prev = 0;
   endtask

   task automatic model_step();
      bit rise;
      rise = global_en && !m_prev;
      for (int i = 0; i < 3; i++) begin
         m_done[i] = 0;
         if (abort) begin
            m_run[i] = 0; m_fin[i] = 0; m_round[i] = 0;
         end else if (!m_run[i]) begin
            if (rise) begin
               m_run[i] = 1; m_fin[i] = 0; m_round[i] = 0;
            end
         end else if (rise) begin
            m_round[i] = 0;
         end else if (global_en) begin
            if (m_round[i] == m_rounds[i] - 1) begin
               m_run[i] = 0; m_fin[i] = 1; m_round[i] = 0; m_res[i] = in_d; m_done[i] = 1;
            end else begin
               m_round[i]++;
            end
         end
      end
      m_prev = global_en;
   endtask

   task automatic check_all();
      logic [31:0] g_out [3];
      logic        g_en [3], g_busy [3], g_done [3];
      logic [31:0] g_round [3];
      logic [31:0] exp_out;
      g_out   = '{out0, out1, out2};
      g_en    = '{en0, en1, en2};
      g_busy  = '{busy0, busy1, busy2};
      g_done  = '{done0, done1, done2};
      g_round = '{32'(round0), 32'(round1), 32'(round2)};
      for (int i = 0; i < 3; i++) begin
         if (m_run[i])
            exp_out = (m_round[i] == 0) ? ct : in_d;
         else
            exp_out = (m_fin[i] && m_hold[i]) ? m_res[i] : ct;
         chk($sformatf("out%0d", i),   g_out[i],          exp_out);
         chk($sformatf("en%0d", i),    32'(g_en[i]),      32'(m_run[i]));
         chk($sformatf("busy%0d", i),  32'(g_busy[i]),    32'(m_run[i]));
         chk($sformatf("round%0d", i), g_round[i],        32'(m_round[i]));
         chk($sformatf("done%0d", i),  32'(g_done[i]),    32'(m_done[i]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic run_to_round(input int target);
      int n;
      n = 0;
      while (m_round[0] != target && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("timeout_round", 32'(m_round[0]), 32'(target));
   endtask

   task automatic async_reset_pulse();
      #1 rst_n = 1'b0;
      model_reset();
      #1 check_all();
      chk("rst_done0", 32'(done0), 32'd0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int done_cnt0, done_cnt2, done_at0, done_at2;

      rst_n = 1'b0; global_en = 1'b0; abort = 1'b0;
      ct = 32'hA1B2C3D4; in_d = 32'h11223344;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_out", out0, 32'hA1B2C3D4);
      chk("reset_en", 32'(en0), 32'd0);
      chk("reset_busy", 32'(busy0), 32'd0);
      chk("reset_done", 32'(done0), 32'd0);
      chk("reset_round", 32'(round0), 32'd0);
      check_all();
      rst_n = 1'b1;
      tick();

      // Full unstalled run on all builds.
      global_en = 1'b1;
      done_cnt0 = 0; done_cnt2 = 0; done_at0 = 0; done_at2 = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 1) chk("en_latency", 32'(en0), 32'd1);
         if (done0) begin done_cnt0++; done_at0 = k; end
         if (done2) begin done_cnt2++; done_at2 = k; end
      end
      chk("done0_count", 32'(done_cnt0), 32'd1);
      chk("done0_cycle", 32'(done_at0), 32'd33);
      chk("done2_count", 32'(done_cnt2), 32'd1);
      chk("done2_cycle", 32'(done_at2), 32'd11);
      chk("fin_hold_out", out0, 32'h11223344);
      chk("fin_nohold_out", out1, 32'hA1B2C3D4);

      // Stall at round 10, then restart on re-raise.
      global_en = 1'b0; tick(); tick();
      global_en = 1'b1;
      run_to_round(10);
      global_en = 1'b0;
      repeat (5) tick();
      chk("stall_round", 32'(round0), 32'd10);
      chk("stall_en", 32'(en0), 32'd1);
      global_en = 1'b1;
      tick();
      chk("restart_round", 32'(round0), 32'd0);

      // Abort mid-run, then abort coinciding with a rise.
      run_to_round(20);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_en", 32'(en0), 32'd0);
      chk("abort_out", out0, ct);
      global_en = 1'b0; tick();
      global_en = 1'b1; abort = 1'b1; tick();
      abort = 1'b0; tick(); tick();
      chk("abort_rise_busy", 32'(busy0), 32'd0);

      // Asynchronous reset mid-run.
      global_en = 1'b0; tick();
      global_en = 1'b1;
      run_to_round(15);
      async_reset_pulse();
      chk("rst_mid_round", 32'(round0), 32'd0);
      chk("rst_mid_en", 32'(en0), 32'd0);
      global_en = 1'b0; tick();

      // Randomised phase with varying data, level changes, aborts and resets.
      for (int c = 0; c < 2000; c++) begin
         ct   = $urandom;
         in_d = $urandom;
         if ($urandom_range(0, 39) == 0) global_en = ~global_en;
         abort = ($urandom_range(0, 79) == 0);
         tick();
         if ($urandom_range(0, 299) == 0) async_reset_pulse();
      end
      abort = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
